// File: rtl/alu_cmd_issuer.sv
// Purpose  : buffers (opcode, A, B) commands and issues them one at a time to alu_4bit, returning Result/Error or a timeout.
// Latency  : accept edge E0 -> pop E1 -> start E2 -> capture E3 (1-cycle ALU); rsp_valid the cycle after E3; one op per 4 cycles.
// Backpres.: cmd_ready drops when the command FIFO is full; the response is held in RESP until rsp_ready, blocking the next issue.
module alu_cmd_issuer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_opcode,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_opcode,
    output logic       alu_start,
    input  logic [7:0] alu_result,
    input  logic       alu_done,
    input  logic       alu_error,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_error,
    output logic       rsp_timeout,
    output logic       busy,
    output logic [7:0] issued_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic [1:0] opcode;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    cmd_t             fifo_mem [FIFO_DEPTH];
    cmd_t             fifo_head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] timer;
    logic             capture_done;
    logic             capture_timeout;

    assign fifo_full  = (fifo_cnt == FULL_CNT);
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_head  = fifo_mem[rd_ptr];
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign busy       = (state != ST_IDLE) || !fifo_empty;

    // State register; reset returns to IDLE from anywhere, including mid-WAIT/RESP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the per-state strobes (pop, start pulse, capture, response valid).
    always_comb begin
        state_nxt       = state;
        pop             = 1'b0;
        alu_start       = 1'b0;
        rsp_valid       = 1'b0;
        capture_done    = 1'b0;
        capture_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                alu_start = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Done seen on the final timer cycle still wins over the timeout.
                if (alu_done) begin
                    capture_done = 1'b1;
                    state_nxt    = ST_RESP;
                end else if (timer == TMR_LAST) begin
                    capture_timeout = 1'b1;
                    state_nxt       = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            fifo_mem[wr_ptr] <= '{opcode: cmd_opcode, a: cmd_a, b: cmd_b};
        end
    end

    // ALU operand registers, loaded on pop and held through ISSUE, WAIT and RESP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
        end else if (pop) begin
            alu_a      <= fifo_head.a;
            alu_b      <= fifo_head.b;
            alu_opcode <= fifo_head.opcode;
        end
    end

    // WAIT-cycle timer, cleared on issue and advanced while Done is absent.
    always_ff @(posedge clk) begin
        if (!reset) begin
            timer <= '0;
        end else if (state == ST_ISSUE) begin
            timer <= '0;
        end else if (state == ST_WAIT && !alu_done && timer != TMR_LAST) begin
            timer <= timer + TMR_W'(1);
        end
    end

    // Count of start pulses since reset; wraps naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            issued_count <= '0;
        end else if (alu_start) begin
            issued_count <= issued_count + 8'd1;
        end
    end

    // Response capture: ALU outputs on Done, zeros plus timeout flag when abandoned.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_result  <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (capture_done) begin
            rsp_result  <= alu_result;
            rsp_error   <= alu_error;
            rsp_timeout <= 1'b0;
        end else if (capture_timeout) begin
            rsp_result  <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Purpose  : self-checking bench for alu_cmd_issuer with a behavioural ALU and a queue-based reference model.
// Latency  : n/a (bench).
// Backpres.: drives random cmd_valid / rsp_ready and variable ALU latency, including never-Done.
module tb_alu_cmd_issuer;

    localparam int TIMEOUT = 16;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_opcode;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_opcode;
    logic       alu_start;
    logic [7:0] alu_result;
    logic       alu_done;
    logic       alu_error;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_error;
    logic       rsp_timeout;
    logic       busy;
    logic [7:0] issued_count;

    alu_cmd_issuer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_start(alu_start),
        .alu_result(alu_result), .alu_done(alu_done), .alu_error(alu_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .busy(busy), .issued_count(issued_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state: commands accepted but not yet issued, responses owed.
    logic [9:0] exp_issue[$];
    logic [9:0] exp_rsp[$];
    int   acc_cnt = 0, start_cnt = 0, rsp_cnt = 0;
    int   accept_cyc = 0, start_cyc = 0, rsp_first_cyc = 0;
    logic prev_start = 1'b0, rsp_hold = 1'b0;
    logic [7:0] last_result = '0;
    logic last_error = 1'b0, last_timeout = 1'b0;
    int   alu_lat = 1;
    logic force_done = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ALU arithmetic as the alu_4bit datasheet describes it: {error, result}.
    function automatic logic [8:0] alu_ref(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int   r;
        logic e;
        e = 1'b0;
        r = 0;
        case (op)
            2'd0: r = int'(a) + int'(b);
            2'd1: r = int'(a) - int'(b);
            2'd2: r = int'(a) * int'(b);
            default: begin
                if (b == 4'd0) begin
                    e = 1'b1;
                    r = 0;
                end else begin
                    r = int'(a) / int'(b);
                end
            end
        endcase
        return {e, 8'(r & 255)};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: Done alu_lat cycles after start (0 = never); garbage on Result/Error otherwise.
    initial begin
        int         cnt;
        logic       fire;
        logic [8:0] pend;
        cnt = 0;
        pend = '0;
        alu_done = 1'b0;
        alu_result = '0;
        alu_error = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cnt = 0;
            end else if (alu_start) begin
                cnt  = alu_lat;
                pend = alu_ref(alu_opcode, alu_a, alu_b);
            end
            @(posedge clk);
            #2;
            fire = 1'b0;
            if (cnt > 0) begin
                cnt--;
                fire = (cnt == 0);
            end
            if (fire) begin
                alu_done   = 1'b1;
                alu_error  = pend[8];
                alu_result = pend[7:0];
            end else begin
                alu_done   = force_done;
                alu_result = 8'($urandom);
                alu_error  = 1'($urandom);
            end
        end
    end

    // Monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        logic [9:0] ent;
        logic [9:0] er;
        if (!reset) begin
            exp_issue.delete();
            exp_rsp.delete();
            start_cnt  = 0;
            prev_start = 1'b0;
            rsp_hold   = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                exp_issue.push_back({cmd_opcode, cmd_a, cmd_b});
                accept_cyc = cyc;
                acc_cnt++;
            end
            if (alu_start) begin
                check_val("start_single_cycle", prev_start, 0);
                check_val("start_while_outstanding", exp_rsp.size(), 0);
                if (exp_issue.size() == 0) begin
                    check_val("start_without_cmd", 1, 0);
                end else begin
                    ent = exp_issue.pop_front();
                    check_val("issue_cmd", {alu_opcode, alu_a, alu_b}, ent);
                    if (alu_lat == 0 || alu_lat > TIMEOUT)
                        er = 10'b10_0000_0000;
                    else
                        er = {1'b0, alu_ref(ent[9:8], ent[7:4], ent[3:0])};
                    exp_rsp.push_back(er);
                end
                start_cnt++;
                start_cyc = cyc;
            end
            prev_start = alu_start;
            if (rsp_valid) begin
                if (!rsp_hold) rsp_first_cyc = cyc;
                if (exp_rsp.size() == 0) begin
                    check_val("rsp_unexpected", 1, 0);
                end else begin
                    check_val("rsp_fields", {rsp_timeout, rsp_error, rsp_result}, exp_rsp[0]);
                    if (rsp_ready) void'(exp_rsp.pop_front());
                end
                if (rsp_ready) begin
                    rsp_cnt++;
                    last_result  = rsp_result;
                    last_error   = rsp_error;
                    last_timeout = rsp_timeout;
                end
            end
            rsp_hold = rsp_valid && !rsp_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic acc;
        acc = 1'b0;
        cmd_opcode = op;
        cmd_a = a;
        cmd_b = b;
        cmd_valid = 1'b1;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            acc = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        if (!acc) check_val("send_cmd_bound", 0, 1);
    endtask

    task automatic wait_idle(input int max);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < max && !ok; k++) begin
            @(negedge clk);
            ok = !busy && exp_rsp.size() == 0 && exp_issue.size() == 0;
        end
        tick();
        if (!ok) check_val("wait_idle_bound", 0, 1);
    endtask

    task automatic wait_start(input int max);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < max && !ok; k++) begin
            @(negedge clk);
            ok = alu_start;
        end
        tick();
        if (!ok) check_val("wait_start_bound", 0, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] t4_op [6];
        logic [3:0] t4_a  [6];
        logic [3:0] t4_b  [6];
        int   s0, r0, idx, sent, ra0;
        logic acc;

        reset = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0;
        rsp_ready = 1'b1; alu_lat = 1; force_done = 1'b0;

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_cmd_ready", cmd_ready, 1);
        check_val("rst_outputs", {alu_a, alu_b, alu_opcode, alu_start, rsp_valid,
                                  rsp_result, rsp_error, rsp_timeout, busy}, 0);
        check_val("rst_issued_count", issued_count, 0);
        tick();
        reset = 1'b1;

        // ADD 5+3 with a 1-cycle ALU.
        send_cmd(2'd0, 4'd5, 4'd3);
        wait_idle(50);
        check_val("add_latency", rsp_first_cyc - accept_cyc, 4);
        check_val("add_starts", start_cnt, 1);
        check_val("add_issued_count", issued_count, 1);
        check_val("add_result", {last_timeout, last_error, last_result}, 10'd8);
        check_val("add_operands_held", {alu_opcode, alu_a, alu_b}, {2'd0, 4'd5, 4'd3});

        // DIV by zero after a fresh reset.
        do_reset();
        send_cmd(2'd3, 4'd8, 4'd0);
        wait_idle(50);
        check_val("div0_issued_count", issued_count, 1);
        check_val("div0_rsp", {last_timeout, last_error, last_result}, 10'b01_0000_0000);

        // Response blocked: FIFO plus the in-flight op absorb exactly five commands.
        t4_op = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd0, 2'd1};
        t4_a  = '{4'd10, 4'd5, 4'd1, 4'd9, 4'd15, 4'd3};
        t4_b  = '{4'd4, 4'd3, 4'd2, 4'd2, 4'd15, 4'd7};
        rsp_ready = 1'b0;
        s0 = start_cnt;
        r0 = rsp_cnt;
        idx = 0;
        for (int k = 0; k < 12; k++) begin
            cmd_valid  = 1'b1;
            cmd_opcode = t4_op[idx];
            cmd_a      = t4_a[idx];
            cmd_b      = t4_b[idx];
            @(negedge clk);
            acc = cmd_ready;
            tick();
            if (acc && idx < 5) idx++;
            else if (acc) idx = 6;
        end
        cmd_valid = 1'b0;
        check_val("full_accepted", idx, 5);
        @(negedge clk);
        check_val("full_cmd_ready", cmd_ready, 0);
        check_val("full_one_start", start_cnt - s0, 1);
        check_val("full_rsp_valid", rsp_valid, 1);
        tick();
        rsp_ready = 1'b1;
        wait_idle(200);
        check_val("drain_starts", start_cnt - s0, 5);
        check_val("drain_rsps", rsp_cnt - r0, 5);

        // Timeout: ALU never answers.
        alu_lat = 0;
        send_cmd(2'd0, 4'd7, 4'd7);
        wait_idle(80);
        check_val("to_wait_cycles", rsp_first_cyc - start_cyc, TIMEOUT + 1);
        check_val("to_rsp", {last_timeout, last_error, last_result}, 10'b10_0000_0000);

        // Done on the final WAIT cycle beats the timeout.
        alu_lat = TIMEOUT;
        send_cmd(2'd2, 4'd7, 4'd7);
        wait_idle(80);
        check_val("late_done_cycles", rsp_first_cyc - start_cyc, TIMEOUT + 1);
        check_val("late_done_rsp", {last_timeout, last_error, last_result}, 10'd49);

        // Done one cycle too late: timeout, and the stray Done is ignored.
        alu_lat = TIMEOUT + 1;
        send_cmd(2'd2, 4'd3, 4'd3);
        wait_idle(80);
        check_val("too_late_rsp", {last_timeout, last_error, last_result}, 10'b10_0000_0000);
        r0 = rsp_cnt;
        repeat (4) tick();
        check_val("stray_done_no_rsp", rsp_cnt - r0, 0);
        check_val("stray_done_busy", busy, 0);

        // Reset during WAIT, then a Done right after release.
        alu_lat = 0;
        send_cmd(2'd1, 4'd9, 4'd2);
        wait_start(20);
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        force_done = 1'b1;
        tick();
        tick();
        force_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_val("rst_wait_no_rsp", rsp_valid, 0);
            tick();
        end
        @(negedge clk);
        check_val("rst_wait_busy", busy, 0);
        check_val("rst_wait_cmd_ready", cmd_ready, 1);
        check_val("rst_wait_issued", issued_count, 0);
        tick();

        // Randomized traffic against the scoreboard.
        do_reset();
        r0 = rsp_cnt;
        ra0 = acc_cnt;
        sent = 0;
        for (int k = 0; k < 20000 && sent < 150; k++) begin
            if (!cmd_valid && $urandom_range(0, 99) < 60) begin
                cmd_valid  = 1'b1;
                cmd_opcode = 2'($urandom);
                cmd_a      = 4'($urandom);
                cmd_b      = 4'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            end
            rsp_ready = ($urandom_range(0, 99) < 70);
            alu_lat   = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 6));
            @(negedge clk);
            acc = cmd_valid && cmd_ready;
            tick();
            if (acc) begin
                cmd_valid = 1'b0;
                sent++;
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        alu_lat   = 1;
        wait_idle(500);
        check_val("rand_sent", sent, 150);
        check_val("rand_accepted", acc_cnt - ra0, 150);
        check_val("rand_rsps", rsp_cnt - r0, 150);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
